// File: rtl/brt_usb_20_utmi_pkg.sv
// Shared types and constants for the UTMI 2.0 transmit controller.
package brt_usb_20_utmi_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      GAP   = 2'd1,
      TX    = 2'd2,
      DRAIN = 2'd3
   } utmi_tx_state_e;

   localparam logic [1:0] UTMI_OPMODE_NORMAL     = 2'b00;
   localparam logic [1:0] UTMI_OPMODE_NONDRV     = 2'b01;
   localparam logic [1:0] UTMI_OPMODE_NOBITSTUFF = 2'b10;

   // One-hot packet owner: bit0 handshake/token source, bit1 data source.
   typedef enum logic [1:0] {
      GNT_NONE = 2'b00,
      GNT_HS   = 2'b01,
      GNT_DP   = 2'b10
   } utmi_tx_grant_e;

endpackage

// File: rtl/brt_usb_20_utmi_tx_ctrl_if.sv
// Source streams, line configuration and UTMI TX signals of the transmit controller.
interface brt_usb_20_utmi_tx_ctrl_if;
   logic        hs_valid;
   logic [7:0]  hs_data;
   logic        hs_last;
   logic        hs_ready;
   logic        dp_valid;
   logic [7:0]  dp_data;
   logic        dp_last;
   logic        dp_ready;
   logic [1:0]  cfg_opmode;
   logic        cfg_xcvrselect;
   logic        cfg_termselect;
   logic        cfg_suspendm;
   logic        utmitxready;
   logic        utmirxactive;
   logic [15:0] utmidatao;
   logic        utmitxvalid;
   logic        utmixcvrselect;
   logic        utmitermselect;
   logic        utmisuspendm;
   logic [1:0]  utmiopmode;
   logic [1:0]  tx_grant;
   logic        tx_done;
   logic        err_underrun;
   logic        err_timeout;

   // master: the controller; slave: the sources and PHY around it
   modport master (
      input  hs_valid, hs_data, hs_last, dp_valid, dp_data, dp_last,
      input  cfg_opmode, cfg_xcvrselect, cfg_termselect, cfg_suspendm,
      input  utmitxready, utmirxactive,
      output hs_ready, dp_ready, utmidatao, utmitxvalid, utmixcvrselect,
      output utmitermselect, utmisuspendm, utmiopmode, tx_grant,
      output tx_done, err_underrun, err_timeout
   );

   modport slave (
      output hs_valid, hs_data, hs_last, dp_valid, dp_data, dp_last,
      output cfg_opmode, cfg_xcvrselect, cfg_termselect, cfg_suspendm,
      output utmitxready, utmirxactive,
      input  hs_ready, dp_ready, utmidatao, utmitxvalid, utmixcvrselect,
      input  utmitermselect, utmisuspendm, utmiopmode, tx_grant,
      input  tx_done, err_underrun, err_timeout
   );
endinterface

// File: rtl/brt_usb_20_utmi_gap_timer.sv
// Loadable down-counter with zero flag, used to time the inter-packet gap.
module brt_usb_20_utmi_gap_timer #(
   parameter int             W    = 8,
   parameter logic [W-1:0]   INIT = '0
) (
   input  logic clk,
   input  logic rst,
   input  logic load,
   input  logic dec,
   output logic zero
);
   logic [W-1:0] cnt;

   always_ff @(posedge clk) begin
      if (rst)                     cnt <= INIT;
      else if (load)               cnt <= INIT;
      else if (dec && cnt != '0)   cnt <= cnt - 1'b1;
   end

   assign zero = (cnt == '0);
endmodule

// File: rtl/brt_usb_20_utmi_tx_ctrl.sv
// UTMI 2.0 transmit controller: HS/DP arbitration, txvalid/txready handshake,
// inter-packet gap, underrun/timeout handling and idle-only line configuration.
module brt_usb_20_utmi_tx_ctrl
   import brt_usb_20_utmi_pkg::*;
#(
   parameter int IPG_CYCLES      = 8,
   parameter int TXREADY_TIMEOUT = 1024
) (
   input  logic                          clk_utmi,
   input  logic                          rst_utmi,
   brt_usb_20_utmi_tx_ctrl_if.master     u
);
   localparam int TO_W = $clog2(TXREADY_TIMEOUT + 1);

   utmi_tx_state_e state, state_n;
   utmi_tx_grant_e grant, grant_n;
   logic           txvalid, txvalid_n;
   logic [7:0]     cur_data, cur_data_n;
   logic           cur_last, cur_last_n;
   logic           done, done_n, und, und_n, tmo, tmo_n;
   logic [1:0]     opmode, opmode_n;
   logic           xcvr, xcvr_n, term, term_n, susp, susp_n;
   logic [TO_W-1:0] to_cnt, to_cnt_n;
   logic           hs_rdy, dp_rdy, gap_load, gap_dec, gap_zero;
   logic           sel_valid, sel_last;

   brt_usb_20_utmi_gap_timer #(.W(8), .INIT(8'(IPG_CYCLES))) u_gap (
      .clk(clk_utmi), .rst(rst_utmi), .load(gap_load), .dec(gap_dec), .zero(gap_zero)
   );

   assign sel_valid = (grant == GNT_HS) ? u.hs_valid : u.dp_valid;
   assign sel_last  = (grant == GNT_HS) ? u.hs_last  : u.dp_last;

   always_comb begin
      state_n    = state;
      grant_n    = grant;
      txvalid_n  = txvalid;
      cur_data_n = cur_data;
      cur_last_n = cur_last;
      done_n     = 1'b0;
      und_n      = 1'b0;
      tmo_n      = 1'b0;
      opmode_n   = opmode;
      xcvr_n     = xcvr;
      term_n     = term;
      susp_n     = susp;
      to_cnt_n   = to_cnt;
      hs_rdy     = 1'b0;
      dp_rdy     = 1'b0;
      gap_load   = 1'b0;
      gap_dec    = 1'b0;
      case (state)
         GAP: begin
            if (u.utmirxactive) gap_load = 1'b1;
            else if (gap_zero)  state_n  = IDLE;
            else                gap_dec  = 1'b1;
         end
         IDLE: begin
            if (!u.utmirxactive && (u.hs_valid || u.dp_valid)) begin
               hs_rdy     = u.hs_valid;
               dp_rdy     = !u.hs_valid;
               grant_n    = u.hs_valid ? GNT_HS : GNT_DP;
               cur_data_n = u.hs_valid ? u.hs_data : u.dp_data;
               cur_last_n = u.hs_valid ? u.hs_last : u.dp_last;
               txvalid_n  = 1'b1;
               to_cnt_n   = '0;
               state_n    = TX;
            end else begin
               // line config only follows the request while nothing is granted
               opmode_n = u.cfg_opmode;
               xcvr_n   = u.cfg_xcvrselect;
               term_n   = u.cfg_termselect;
               susp_n   = u.cfg_suspendm;
               if (u.utmirxactive) begin
                  state_n  = GAP;
                  gap_load = 1'b1;
               end
            end
         end
         TX: begin
            if (u.utmitxready) begin
               to_cnt_n = '0;
               if (cur_last) begin
                  txvalid_n = 1'b0;
                  done_n    = 1'b1;
                  grant_n   = GNT_NONE;
                  state_n   = GAP;
                  gap_load  = 1'b1;
               end else if (sel_valid) begin
                  hs_rdy     = (grant == GNT_HS);
                  dp_rdy     = (grant == GNT_DP);
                  cur_data_n = (grant == GNT_HS) ? u.hs_data : u.dp_data;
                  cur_last_n = sel_last;
               end else begin
                  txvalid_n = 1'b0;
                  und_n     = 1'b1;
                  state_n   = DRAIN;
               end
            end else if (to_cnt == TO_W'(TXREADY_TIMEOUT - 1)) begin
               txvalid_n = 1'b0;
               tmo_n     = 1'b1;
               if (cur_last) begin
                  grant_n  = GNT_NONE;
                  state_n  = GAP;
                  gap_load = 1'b1;
               end else begin
                  state_n  = DRAIN;
               end
            end else begin
               to_cnt_n = to_cnt + 1'b1;
            end
         end
         DRAIN: begin
            hs_rdy = (grant == GNT_HS);
            dp_rdy = (grant == GNT_DP);
            if (sel_valid && sel_last) begin
               grant_n  = GNT_NONE;
               state_n  = GAP;
               gap_load = 1'b1;
            end
         end
         default: state_n = GAP;
      endcase
   end

   always_ff @(posedge clk_utmi) begin
      if (rst_utmi) begin
         state    <= GAP;
         grant    <= GNT_NONE;
         txvalid  <= 1'b0;
         cur_data <= 8'h00;
         cur_last <= 1'b0;
         done     <= 1'b0;
         und      <= 1'b0;
         tmo      <= 1'b0;
         opmode   <= UTMI_OPMODE_NORMAL;
         xcvr     <= 1'b1;
         term     <= 1'b1;
         susp     <= 1'b1;
         to_cnt   <= '0;
      end else begin
         state    <= state_n;
         grant    <= grant_n;
         txvalid  <= txvalid_n;
         cur_data <= cur_data_n;
         cur_last <= cur_last_n;
         done     <= done_n;
         und      <= und_n;
         tmo      <= tmo_n;
         opmode   <= opmode_n;
         xcvr     <= xcvr_n;
         term     <= term_n;
         susp     <= susp_n;
         to_cnt   <= to_cnt_n;
      end
   end

   // ready is combinational; mask it so nothing is consumed while in reset
   assign u.hs_ready       = hs_rdy & ~rst_utmi;
   assign u.dp_ready       = dp_rdy & ~rst_utmi;
   assign u.utmidatao      = {8'h00, cur_data};
   assign u.utmitxvalid    = txvalid;
   assign u.tx_grant       = grant;
   assign u.tx_done        = done;
   assign u.err_underrun   = und;
   assign u.err_timeout    = tmo;
   assign u.utmiopmode     = opmode;
   assign u.utmixcvrselect = xcvr;
   assign u.utmitermselect = term;
   assign u.utmisuspendm   = susp;
endmodule

// File: tb/tb_brt_usb_20_utmi_tx_ctrl.sv
// Bench for brt_usb_20_utmi_tx_ctrl: queue-driven sources and PHY, cycle-stamped monitor.
module tb_brt_usb_20_utmi_tx_ctrl;
   localparam int IPG = 8;
   localparam int TMO = 16;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   brt_usb_20_utmi_tx_ctrl_if u_if ();

   brt_usb_20_utmi_tx_ctrl #(.IPG_CYCLES(IPG), .TXREADY_TIMEOUT(TMO)) dut (
      .clk_utmi(clk), .rst_utmi(rst), .u(u_if)
   );

   int checks = 0, passes = 0, cyc = 0;
   // source queue entries: [9] bubble (one idle cycle), [8] last, [7:0] data
   logic [9:0]  hs_q[$], dp_q[$];
   logic [7:0]  exp_b[$];
   logic [15:0] byte_q[$];
   logic [1:0]  gnt_q[$];
   int rise_q[$], fall_q[$], acc_q[$], done_q[$], und_q[$], to_q[$];
   int hs_cons_q[$], dp_cons_q[$], opm_q[$];
   int hold_err = 0, mode = 0, rxfall = 0;
   logic lvl = 1'b0, hs_fire = 1'b0, dp_fire = 1'b0, dp_bub = 1'b0;
   logic tv_prev = 1'b0, tr_prev = 1'b0, tv_m = 1'b0, tr_m = 1'b0;
   logic [15:0] d_m = '0;
   logic [1:0]  opm_m = '0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) passes++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   // sources and PHY: update just after each rising edge
   always @(posedge clk) begin
      #1;
      if (hs_fire && hs_q.size() > 0) void'(hs_q.pop_front());
      if ((dp_fire || dp_bub) && dp_q.size() > 0) void'(dp_q.pop_front());
      dp_bub = 1'b0;
      u_if.hs_valid = (hs_q.size() > 0);
      u_if.hs_data  = (hs_q.size() > 0) ? hs_q[0][7:0] : 8'h00;
      u_if.hs_last  = (hs_q.size() > 0) ? hs_q[0][8] : 1'b0;
      if (dp_q.size() > 0 && dp_q[0][9]) begin
         u_if.dp_valid = 1'b0;
         dp_bub = 1'b1;
      end else begin
         u_if.dp_valid = (dp_q.size() > 0);
      end
      u_if.dp_data = (dp_q.size() > 0) ? dp_q[0][7:0] : 8'h00;
      u_if.dp_last = (dp_q.size() > 0) ? dp_q[0][8] : 1'b0;
      case (mode)
         0:       u_if.utmitxready = lvl;
         1:       u_if.utmitxready = ~tr_prev;
         2:       u_if.utmitxready = ($urandom_range(3, 0) != 0);
         default: u_if.utmitxready = u_if.utmitxvalid && tv_prev && !tr_prev;
      endcase
      tv_prev = u_if.utmitxvalid;
      tr_prev = u_if.utmitxready;
   end

   // monitor: one snapshot per cycle, mid-cycle
   always @(negedge clk) begin
      cyc++;
      hs_fire = u_if.hs_valid && u_if.hs_ready;
      dp_fire = u_if.dp_valid && u_if.dp_ready;
      if (hs_fire) hs_cons_q.push_back(cyc);
      if (dp_fire) dp_cons_q.push_back(cyc);
      if (u_if.utmitxvalid && !tv_m) begin
         rise_q.push_back(cyc);
         gnt_q.push_back(u_if.tx_grant);
      end
      if (!u_if.utmitxvalid && tv_m) fall_q.push_back(cyc);
      if (u_if.utmitxvalid && u_if.utmitxready) begin
         byte_q.push_back(u_if.utmidatao);
         acc_q.push_back(cyc);
      end
      if (u_if.utmitxvalid && tv_m && !tr_m && u_if.utmidatao !== d_m) hold_err++;
      if (u_if.tx_done)      done_q.push_back(cyc);
      if (u_if.err_underrun) und_q.push_back(cyc);
      if (u_if.err_timeout)  to_q.push_back(cyc);
      if (u_if.utmiopmode !== opm_m) opm_q.push_back(cyc);
      tv_m  = u_if.utmitxvalid;
      tr_m  = u_if.utmitxready;
      d_m   = u_if.utmidatao;
      opm_m = u_if.utmiopmode;
   end

   task automatic clear();
      byte_q.delete(); gnt_q.delete(); rise_q.delete(); fall_q.delete(); acc_q.delete();
      done_q.delete(); und_q.delete(); to_q.delete(); hs_cons_q.delete(); dp_cons_q.delete();
      opm_q.delete(); exp_b.delete(); hold_err = 0;
   endtask

   task automatic push(input bit to_hs, input logic [7:0] d, input logic l, input bit expect_tx);
      if (to_hs) hs_q.push_back({1'b0, l, d});
      else       dp_q.push_back({1'b0, l, d});
      if (expect_tx) exp_b.push_back(d);
   endtask

   task automatic add_rand(input bit to_hs, input int len);
      for (int i = 0; i < len; i++) push(to_hs, 8'($urandom), (i == len - 1), 1'b1);
   endtask

   task automatic wait_quiet();
      int q = 0;
      for (int i = 0; i < 600 && q < 12; i++) begin
         @(negedge clk);
         if (hs_q.size() == 0 && dp_q.size() == 0 && !u_if.utmitxvalid) q++;
         else q = 0;
      end
      chk("quiet_bound", (q >= 12), 1);
   endtask

   task automatic wait_rise();
      int i = 0;
      while (i < 200 && u_if.utmitxvalid !== 1'b1) begin
         @(negedge clk);
         i++;
      end
      chk("rise_bound", u_if.utmitxvalid, 1'b1);
   endtask

   task automatic check_bytes(input string tag);
      chk({tag, "_nbytes"}, byte_q.size(), exp_b.size());
      for (int i = 0; i < byte_q.size() && i < exp_b.size(); i++)
         chk({tag, "_byte"}, byte_q[i], {8'h00, exp_b[i]});
   endtask

   initial begin
      rst = 1'b1;
      u_if.utmirxactive = 1'b0; u_if.utmitxready = 1'b0;
      u_if.hs_valid = 1'b0; u_if.hs_data = '0; u_if.hs_last = 1'b0;
      u_if.dp_valid = 1'b0; u_if.dp_data = '0; u_if.dp_last = 1'b0;
      u_if.cfg_opmode = 2'b01; u_if.cfg_xcvrselect = 1'b0;
      u_if.cfg_termselect = 1'b0; u_if.cfg_suspendm = 1'b0;
      mode = 3;
      push(1'b1, 8'hD2, 1'b1, 1'b1);
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_txvalid", u_if.utmitxvalid, 0);
      chk("rst_datao", u_if.utmidatao, 0);
      chk("rst_grant", u_if.tx_grant, 0);
      chk("rst_pulses", {u_if.tx_done, u_if.err_underrun, u_if.err_timeout}, 0);
      chk("rst_hs_ready", {u_if.hs_valid, u_if.hs_ready, u_if.dp_ready}, 3'b100);
      chk("rst_opmode", u_if.utmiopmode, 2'b00);
      chk("rst_cfg", {u_if.utmixcvrselect, u_if.utmitermselect, u_if.utmisuspendm}, 3'b111);
      @(posedge clk); #2;
      rst = 1'b0;
      byte_q.delete(); opm_q.delete(); rise_q.delete(); fall_q.delete(); done_q.delete();
      gnt_q.delete();
      // ACK accepted on its second txvalid cycle
      wait_quiet();
      check_bytes("ack");
      chk("ack_len", fall_q[0] - rise_q[0], 2);
      chk("ack_grant", gnt_q[0], 2'b01);
      chk("ack_done_n", done_q.size(), 1);
      chk("ack_done_cyc", done_q[0], fall_q[0]);
      chk("cfg_upd_n", opm_q.size(), 1);
      chk("cfg_upd_cyc", opm_q[0], fall_q[0] + IPG + 2);
      chk("cfg_applied", {u_if.utmiopmode, u_if.utmixcvrselect, u_if.utmitermselect, u_if.utmisuspendm}, 5'b01000);
      @(posedge clk); #2;
      u_if.cfg_opmode = 2'b00; u_if.cfg_xcvrselect = 1'b1;
      u_if.cfg_termselect = 1'b1; u_if.cfg_suspendm = 1'b1;
      repeat (3) @(posedge clk); #2;

      // DP packet, txready every other cycle
      clear(); mode = 1;
      push(1'b0, 8'hC3, 1'b0, 1'b1); push(1'b0, 8'h01, 1'b0, 1'b1); push(1'b0, 8'h02, 1'b0, 1'b1);
      push(1'b0, 8'hE5, 1'b0, 1'b1); push(1'b0, 8'hF1, 1'b1, 1'b1);
      wait_quiet();
      check_bytes("dp5");
      chk("dp5_hold", hold_err, 0);
      chk("dp5_grant", gnt_q[0], 2'b10);
      chk("dp5_done_n", done_q.size(), 1);
      chk("dp5_fall", fall_q[0] - acc_q[acc_q.size() - 1], 1);

      // random packets, random txready
      for (int k = 0; k < 6; k++) begin
         bit src;
         @(posedge clk); #2;
         clear(); mode = 2;
         src = 1'($urandom_range(1, 0));
         add_rand(src, $urandom_range(6, 1));
         wait_quiet();
         check_bytes("rnd");
         chk("rnd_done_n", done_q.size(), 1);
         chk("rnd_grant", gnt_q[0], src ? 2'b01 : 2'b10);
      end

      // simultaneous request: HS first, DP after the gap
      @(posedge clk); #2;
      clear(); mode = 0; lvl = 1'b1;
      add_rand(1'b1, 1);
      add_rand(1'b0, 2);
      wait_quiet();
      check_bytes("arb");
      chk("arb_gnt0", gnt_q[0], 2'b01);
      chk("arb_gnt1", gnt_q[1], 2'b10);
      chk("arb_dp_start", dp_cons_q[0] - fall_q[0], IPG + 1);
      chk("arb_dp_txvalid", rise_q[1] - fall_q[0], IPG + 2);

      // underrun: source idles one cycle after its second byte
      @(posedge clk); #2;
      clear(); mode = 0; lvl = 1'b1;
      push(1'b0, 8'h4B, 1'b0, 1'b1); push(1'b0, 8'h5A, 1'b0, 1'b1);
      dp_q.push_back(10'h200);
      push(1'b0, 8'h69, 1'b0, 1'b0); push(1'b0, 8'h78, 1'b1, 1'b0);
      wait_quiet();
      check_bytes("und");
      chk("und_n", und_q.size(), 1);
      chk("und_cyc", und_q[0], fall_q[0]);
      chk("und_done_n", done_q.size(), 0);
      chk("und_consumed", dp_cons_q.size(), 4);

      // txready stuck low, packet with more bytes: timeout then drain
      @(posedge clk); #2;
      clear(); mode = 0; lvl = 1'b0;
      add_rand(1'b0, 3); exp_b.delete();
      wait_quiet();
      chk("tmo_len", fall_q[0] - rise_q[0], TMO);
      chk("tmo_n", to_q.size(), 1);
      chk("tmo_cyc", to_q[0], fall_q[0]);
      chk("tmo_nbytes", byte_q.size(), 0);
      chk("tmo_consumed", dp_cons_q.size(), 3);
      chk("tmo_done_n", done_q.size(), 0);

      // timeout on a single-byte packet goes straight to the gap
      @(posedge clk); #2;
      clear();
      add_rand(1'b1, 1); exp_b.delete();
      wait_quiet();
      chk("tmo1_len", fall_q[0] - rise_q[0], TMO);
      chk("tmo1_n", to_q.size(), 1);
      chk("tmo1_consumed", hs_cons_q.size(), 1);

      // config request during TX waits for idle
      @(posedge clk); #2;
      clear(); mode = 1;
      add_rand(1'b0, 4);
      wait_rise();
      @(posedge clk); #2;
      u_if.cfg_opmode = 2'b10;
      wait_quiet();
      check_bytes("cfg");
      chk("cfg_n", opm_q.size(), 1);
      chk("cfg_cyc", opm_q[0], fall_q[0] + IPG + 2);
      chk("cfg_val", u_if.utmiopmode, 2'b10);

      // rxactive for 5 cycles while HS waits
      @(posedge clk); #2;
      clear(); mode = 0; lvl = 1'b1;
      u_if.utmirxactive = 1'b1;
      @(posedge clk); #2;
      add_rand(1'b1, 1);
      repeat (4) @(posedge clk);
      #2;
      u_if.utmirxactive = 1'b0;
      rxfall = cyc + 1;
      wait_quiet();
      check_bytes("rx");
      chk("rx_start", hs_cons_q[0] - rxfall, IPG + 1);
      chk("rx_txvalid", rise_q[0] - rxfall, IPG + 2);

      // reset in the middle of a packet
      @(posedge clk); #2;
      clear(); mode = 0; lvl = 1'b0;
      add_rand(1'b0, 3);
      wait_rise();
      repeat (3) @(posedge clk);
      #2;
      rst = 1'b1;
      @(negedge clk);
      chk("mrst_ready", u_if.dp_ready, 0);
      @(negedge clk);
      chk("mrst_txvalid", u_if.utmitxvalid, 0);
      chk("mrst_grant", u_if.tx_grant, 0);
      chk("mrst_pulses", done_q.size() + und_q.size() + to_q.size(), 0);
      @(posedge clk); #2;
      dp_q.delete();
      rst = 1'b0;
      wait_quiet();

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end
endmodule

// File: doc/brt_usb_20_utmi_tx_ctrl.md
Name: brt_usb_20_utmi_tx_ctrl

Overview:
- Transmit-side controller for the UTMI 2.0 port of the USB VIP device model, running in the UTMI clock domain.
- Arbitrates two packet sources: a handshake/token source (HS, high priority) and a data-packet source (DP).
- Drives the UTMI TX handshake (utmitxvalid/utmitxready, 8-bit data mode), enforces inter-packet gap after TX and after RX activity, detects underrun and txready timeout.
- Applies line-configuration outputs (opmode, xcvrselect, termselect, suspendm) only while the bus is idle.

Parameters:
IPG_CYCLES, 8, idle clk_utmi cycles required after TX end or after utmirxactive falls before a new packet may start; legal range 0..255
TXREADY_TIMEOUT, 1024, consecutive cycles of utmitxvalid without utmitxready before abort; >=2
TO_W, $clog2(TXREADY_TIMEOUT+1), timeout counter width (derived)

Ports:
clk_utmi  in  1  UTMI clock; only clock
rst_utmi  in  1  synchronous, active-high reset
hs_valid/hs_data/hs_last  in  1/8/1  HS source byte stream
hs_ready  out  1  HS byte consumed this cycle
dp_valid/dp_data/dp_last  in  1/8/1  DP source byte stream
dp_ready  out  1  DP byte consumed this cycle
cfg_opmode  in  2; cfg_xcvrselect, cfg_termselect, cfg_suspendm  in  1 each; requested line configuration
utmitxready, utmirxactive  in  1 each  from PHY
utmidatao  out  16  TX data; [15:8] always 0
utmitxvalid, utmixcvrselect, utmitermselect, utmisuspendm  out  1 each
utmiopmode  out  2
tx_grant  out  2  one-hot owner (bit0 HS, bit1 DP), 0 when idle
tx_done, err_underrun, err_timeout  out  1 each  single-cycle pulses

Behaviour:
- Clock clk_utmi only; reset synchronous, active-high (rst_utmi).
- Reset values: utmidatao=0, utmitxvalid=0, tx_grant=0, all pulses 0, hs_ready=dp_ready=0, utmiopmode=2'b00, utmixcvrselect=1, utmitermselect=1, utmisuspendm=1, gap counter=IPG_CYCLES, state=GAP.
- Reset mid-packet: txvalid drops the next edge; no pulses; source residue is the sources' problem.
- States: IDLE, GAP, TX, DRAIN.
- GAP: gap counter reloads to IPG_CYCLES whenever utmirxactive=1; otherwise decrements. Move to IDLE when the counter is 0 and rxactive=0. IPG_CYCLES=0 means IDLE the cycle after rxactive low.
- IDLE arbitration (rxactive=0 only):
  - HS wins over DP when both valid (fixed priority, packet-granular lock).
  - Winner's ready=1 combinationally; its byte and last are registered into cur_data/cur_last; tx_grant is set.
  - utmitxvalid=1 next cycle (1-cycle start latency); next state TX.
  - rxactive=1 in IDLE: go to GAP with reload; no grant.
- Config update: in IDLE with no grant, cfg_* are registered to utmi* config outputs each cycle (1-cycle latency). They are held in all other states.
- TX: utmidatao={8'h0,cur_data} held stable until utmitxready=1.
  - txready & cur_last: utmitxvalid=0 next cycle, tx_done pulse, grant cleared, GAP with reload.
  - txready & !cur_last & granted valid: granted ready=1 combinationally, next byte loaded; txvalid stays 1.
  - txready & !cur_last & !granted valid: underrun. txvalid=0 next cycle, err_underrun pulse, go to DRAIN.
- Timeout: a counter clears on each txready and counts cycles with txvalid=1. On reaching TXREADY_TIMEOUT-1 without txready:
  - txvalid=0 next cycle, err_timeout pulse.
  - Next state is DRAIN if !cur_last, else GAP.
- DRAIN: granted ready=1 and bytes are discarded until a byte with last is consumed; then grant cleared, GAP with reload. No tx_done.
- The non-granted source's ready is always 0 outside IDLE.
- utmirxactive rising during TX is ignored (PHY owns collisions); it affects only GAP/IDLE.

Decomposition:
- Package brt_usb_20_utmi_pkg:
  - typedef enum logic [1:0] {IDLE, GAP, TX, DRAIN} utmi_tx_state_e
  - localparam UTMI_OPMODE_NORMAL=2'b00, UTMI_OPMODE_NONDRV=2'b01, UTMI_OPMODE_NOBITSTUFF=2'b10
  - typedef for grant encoding
- One natural sub-module, brt_usb_20_utmi_gap_timer: loadable down-counter with zero flag, used for the IPG. The timeout counter stays inline.

Test Plan:
- Reset, then hs packet {8'hD2} (ACK) with txready on the 2nd txvalid cycle -> txvalid high 2 cycles, utmidatao=16'h00D2, tx_done 1 cycle after acceptance, tx_grant=2'b01 during packet.
- dp packet {C3,01,02,E5,F1} with txready every other cycle -> bytes appear in order, each held until txready; txvalid falls 1 cycle after F1 accepted.
- HS and DP valid in the same IDLE cycle -> HS sent first; DP starts exactly IPG_CYCLES+1 cycles after HS txvalid falls (8 default).
- DP packet where dp_valid drops after 2nd byte accepted -> err_underrun pulse, txvalid low next cycle, remaining bytes drained on dp_ready until dp_last, no tx_done.
- txready held 0 with TXREADY_TIMEOUT=16 -> err_timeout after 16 txvalid cycles, DRAIN then GAP.
- cfg_opmode=2'b10 changed during TX -> utmiopmode stays 2'b00 until IDLE, then 2'b10 one cycle later.
- utmirxactive pulsed for 5 cycles during IDLE with hs_valid=1 -> no txvalid until 8 cycles after rxactive falls.
